// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write bus for im_loader.
//   byte_in/byte_valid/byte_ready : incoming program bytes (valid/ready)
//   im_we/im_addr/im_wdata        : single-cycle word write strobe to IM
// slave  : loader side (consumes bytes, drives the IM write bus)
// master : source/observer side (testbench, host)
interface im_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: receives a big-endian byte stream and writes it as 32-bit words
// into instruction memory starting at BASE_ADDR.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : one-cycle load request (ignored while busy)
//   word_cnt : words to load, clamped to DEPTH, sampled on start
//   bus      : im_loader_if.slave (byte stream in, IM write bus out)
//   busy     : load in progress
//   done     : one-cycle completion pulse
//   err      : checksum mismatch (only with IM_LOADER_CHECKSUM_EN)
// Optional feature: define IM_LOADER_CHECKSUM_EN to append a 4-byte XOR
// checksum trailer after the data words.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] word_cnt,
  im_loader_if.slave  bus,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IW = $clog2(DEPTH) + 1;

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_e;
  localparam state_e POST = CHK;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;
  localparam state_e POST = DONE;
`endif

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     word_q, word_d;
  logic            byte_ready_q, byte_ready_d;
  logic            im_we_q, im_we_d;
  logic [31:0]     im_addr_q, im_addr_d;
  logic [31:0]     im_wdata_q, im_wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]     csum_q, csum_d;
  logic            err_q, err_d;
`endif

  logic            accept;
  logic [31:0]     word_next;
  logic [IW-1:0]   idx_inc;

  assign accept    = bus.byte_valid && byte_ready_q;
  assign word_next = {word_q[23:0], bus.byte_in};
  assign idx_inc   = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = (32'(word_cnt) > DEPTH) ? IW'(DEPTH) : IW'(word_cnt);
          idx_d  = '0;
          bcnt_d = '0;
          word_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d = '0;
          err_d  = 1'b0;
`endif
          state_d = (word_cnt == '0) ? POST : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          word_d = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_inc;
`ifdef IM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ word_q;
`endif
        state_d = (idx_inc == cnt_q) ? POST : RECV;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          word_d = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            err_d   = (word_next != csum_q);
            state_d = DONE;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the next state so they line
    // up with the state they belong to.
    byte_ready_d = (state_d == RECV);
    busy_d       = (state_d == RECV) || (state_d == WRITE);
`ifdef IM_LOADER_CHECKSUM_EN
    if (state_d == CHK) begin
      byte_ready_d = 1'b1;
      busy_d       = 1'b1;
    end
`endif
    done_d     = (state_d == DONE);
    im_we_d    = (state_d == WRITE);
    im_addr_d  = im_we_d ? (BASE_ADDR + (32'(idx_d) << 2)) : '0;
    im_wdata_d = im_we_d ? word_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.im_we      = im_we_q;
  assign bus.im_addr    = im_addr_q;
  assign bus.im_wdata   = im_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef IM_LOADER_CHECKSUM_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: table of load scenarios with randomized data and
// gaps, checked against a word-list reference model, plus hand-written
// sequences for reset abort and the checksum trailer.
module tb_im_loader;

  localparam logic [31:0] BASE  = 32'h00003000;
  localparam int          DEPTH = 4096;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] word_cnt;
  logic        busy, done, err;

  im_loader_if bus ();

  im_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .word_cnt (word_cnt),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  logic [63:0] got_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Bus monitor: record writes, count done pulses, check idle-bus zeros.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      got_q.push_back({bus.im_addr, bus.im_wdata});
      check("addr_align", {30'd0, bus.im_addr[1:0]}, 32'd0);
    end else begin
      check("idle_addr", bus.im_addr, 32'd0);
      check("idle_wdata", bus.im_wdata, 32'd0);
    end
    if (done === 1'b1) begin
      done_cnt++;
      err_at_done = err;
      check("busy_at_done", {31'd0, busy}, 32'd0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit   ok;
    ok = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    for (int t = 0; t < 200; t++) begin
      r = bus.byte_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    bus.byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: a load of n words yields writes i = 0..min(n,DEPTH)-1
  // at BASE + 4*i carrying the i-th sent word; checksum is their XOR.
  task automatic run_load(input int n, input int gap, input bit mid, input bit fixed,
                          input int exp_w, input logic [31:0] exp_last, input bit bad);
    logic [31:0] words[$];
    logic [31:0] x, w, tr;
    int          nw, d0, t, g;
    nw = (n > DEPTH) ? DEPTH : n;
    x  = '0;
    for (int i = 0; i < nw; i++) begin
      w = fixed ? ((i == 0) ? 32'h3C010000 : 32'h34210001) : $urandom();
      words.push_back(w);
      x ^= w;
    end
    got_q.delete();
    d0 = done_cnt;
    start = 1'b1;
    word_cnt = 13'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, (n != 0 || CSUM) ? 32'd1 : 32'd0);
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        if (mid && i == 0 && b == 2) begin
          start = 1'b1;
          word_cnt = 13'd1;
          @(posedge clk); #1;
          start = 1'b0;
          word_cnt = 13'(n);
        end
        g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
        send_byte(w[31-8*b -: 8], g);
      end
    end
    if (CSUM) begin
      tr = bad ? 32'h0 : x;
      for (int b = 0; b < 4; b++) send_byte(tr[31-8*b -: 8], (gap < 0) ? 1 : gap);
    end
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (n == 0 && !CSUM) check("zero_done_latency_le2", {31'd0, (t <= 2)}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("n_writes", 32'(got_q.size()), 32'(exp_w));
    for (int i = 0; i < got_q.size() && i < nw; i++) begin
      check("w_addr", got_q[i][63:32], BASE + 32'(4 * i));
      check("w_data", got_q[i][31:0], words[i]);
    end
    if (got_q.size() > 0) check("last_addr", got_q[got_q.size()-1][63:32], exp_last);
    check("err_at_done", {31'd0, err_at_done}, (CSUM && bad) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    int          n;
    int          gap;      // -1: random gap per byte
    bit          mid;      // pulse start while busy
    bit          fixed;    // use 3C010000 / 34210001 data
    int          exp_w;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] w;
    int d0;
    vecs[0] = '{2,    0,  1'b0, 1'b1, 2,    32'h00003004};
    vecs[1] = '{2,    3,  1'b0, 1'b1, 2,    32'h00003004};
    vecs[2] = '{0,    0,  1'b0, 1'b0, 0,    32'h00000000};
    vecs[3] = '{3,    1,  1'b1, 1'b0, 3,    32'h00003008};
    vecs[4] = '{7,    -1, 1'b0, 1'b0, 7,    32'h00003018};
    vecs[5] = '{5000, 0,  1'b0, 1'b0, 4096, 32'h00006FFC};

    reset = 1'b0;
    start = 1'b0;
    word_cnt = '0;
    bus.byte_valid = 1'b0;
    bus.byte_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_we", {31'd0, bus.im_we}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_load(vecs[i].n, vecs[i].gap, vecs[i].mid, vecs[i].fixed,
               vecs[i].exp_w, vecs[i].exp_last, 1'b0);

    // Reset after 6 of 8 bytes: only the first word lands, no done.
    got_q.delete();
    d0 = done_cnt;
    start = 1'b1;
    word_cnt = 13'd2;
    @(posedge clk); #1;
    start = 1'b0;
    w = 32'h3C010000;
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 0);
    w = 32'h34210001;
    for (int b = 0; b < 2; b++) send_byte(w[31-8*b -: 8], 0);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("abort_we", {31'd0, bus.im_we}, 32'd0);
    check("abort_addr", bus.im_addr, 32'd0);
    check("abort_wdata", bus.im_wdata, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_n_writes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("abort_w0_addr", got_q[0][63:32], 32'h00003000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_n_writes_after", 32'(got_q.size()), 32'd1);
    run_load(1, 0, 1'b0, 1'b0, 1, BASE, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    run_load(2, 0, 1'b0, 1'b1, 2, 32'h00003004, 1'b1);
    run_load(2, 2, 1'b0, 1'b1, 2, 32'h00003004, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
